tx_fifo_periph: RTL and testbench

//  Data-memory-bus responder for the MiniRISC CPU. It is the slave end of the bus that the datapath drives.
//  - CPU writes bytes into an internal FIFO through memory-mapped registers.
//  - The FIFO drains to a valid/ready byte stream towards an off-CPU consumer (UART TX, LED shifter, etc.).
//  - Reads drive a wired-OR data bus and return 0 when the block is not addressed.

---
 rtl/tx_fifo_periph_pkg.sv | 49 ++++
 rtl/tx_fifo_periph_if.sv | 23 ++
 rtl/tx_fifo_periph_sync_fifo.sv | 57 +++++
 rtl/tx_fifo_periph.sv | 112 +++++++++++
 tb/tb_tx_fifo_periph.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_fifo_periph_pkg.sv
// Shared register map, bit positions and packing helpers for tx_fifo_periph.
// The interrupt path is compiled in only when FIFO_IRQ_EN is defined.
package tx_fifo_periph_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_COUNT  = 2'd2,
        REG_CTRL   = 2'd3
    } reg_sel_e;

    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_IRQ_PEND = 3;

    localparam int CT_OUT_EN  = 0;
    localparam int CT_FLUSH   = 1;
    localparam int CT_IRQ_EN  = 2;
    localparam int CT_OVF_CLR = 3;

    function automatic logic [7:0] pack_status(
        input logic empty,
        input logic full,
        input logic ovf,
        input logic irq_pend
    );
        logic [7:0] v;
        v = '0;
        v[ST_EMPTY]    = empty;
        v[ST_FULL]     = full;
        v[ST_OVF]      = ovf;
        v[ST_IRQ_PEND] = irq_pend;
        return v;
    endfunction

    // flush and ovf_clr are pulses, so they always read back as zero.
    function automatic logic [7:0] pack_ctrl(
        input logic out_en,
        input logic irq_en
    );
        logic [7:0] v;
        v = '0;
        v[CT_OUT_EN] = out_en;
        v[CT_IRQ_EN] = irq_en;
        return v;
    endfunction

endpackage

// File: rtl/tx_fifo_periph_if.sv
// CPU data-memory bus plus outgoing byte stream and interrupt of tx_fifo_periph.
// Stream handshake: a byte moves on a rising edge where m_valid & m_ready are both high.
interface tx_fifo_periph_if;
    logic [7:0] mem_addr;
    logic       mem_wr;
    logic       mem_rd;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       irq;

    modport master (
        output mem_addr, mem_wr, mem_rd, mem_wr_data, m_ready,
        input  mem_rd_data, m_data, m_valid, irq
    );

    modport slave (
        input  mem_addr, mem_wr, mem_rd, mem_wr_data, m_ready,
        output mem_rd_data, m_data, m_valid, irq
    );
endinterface

// File: rtl/tx_fifo_periph_sync_fifo.sv
// Synchronous FIFO with register storage and an asynchronous head read.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == FULL_CNT);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            r_count <= r_count + (DEPTH_LOG2+1)'(w_do_push) - (DEPTH_LOG2+1)'(w_do_pop);
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (w_do_push && !flush && !rst) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/tx_fifo_periph.sv
// Memory-mapped byte FIFO that drains to a valid/ready stream; reads are wired-OR (0 when not addressed).
// Define FIFO_IRQ_EN to build the empty-FIFO interrupt (irq_en, irq_pend, irq).
module tx_fifo_periph
    import tx_fifo_periph_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'hC0,
    parameter int         DEPTH_LOG2 = 4
) (
    input logic             clk,
    input logic             rst,
    tx_fifo_periph_if.slave bus
);
    logic                w_hit;
    reg_sel_e            w_sel;
    logic                w_wr_data;
    logic                w_wr_ctrl;
    logic                w_flush;
    logic                w_ovf_clr;
    logic                w_pop;
    logic                w_ovf_set;
    logic [7:0]          w_dout;
    logic                w_empty;
    logic                w_full;
    logic [DEPTH_LOG2:0] w_count;
    logic                w_irq_en;
    logic                w_irq;
    logic [7:0]          w_rd_data;
    logic                w_unused;

    logic                r_out_en;
    logic                r_ovf;

    assign w_hit     = (bus.mem_addr[7:2] == BASE_ADDR[7:2]);
    assign w_sel     = reg_sel_e'(bus.mem_addr[1:0]);
    assign w_wr_data = bus.mem_wr & w_hit & (w_sel == REG_DATA);
    assign w_wr_ctrl = bus.mem_wr & w_hit & (w_sel == REG_CTRL);
    assign w_flush   = w_wr_ctrl & bus.mem_wr_data[CT_FLUSH];
    assign w_ovf_clr = w_wr_ctrl & bus.mem_wr_data[CT_OVF_CLR];
    assign w_pop     = bus.m_valid & bus.m_ready;
    // A push into a full FIFO is only lost when nothing leaves in the same cycle.
    assign w_ovf_set = w_wr_data & w_full & ~w_pop;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_wr_data),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (bus.mem_wr_data),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_en <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_out_en <= bus.mem_wr_data[CT_OUT_EN];
            if (w_ovf_set)      r_ovf <= 1'b1;
            else if (w_ovf_clr) r_ovf <= 1'b0;
        end
    end

`ifdef FIFO_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    // Rises one cycle after irq_en & empty holds; drops on the push edge or the edge that clears irq_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_irq_en <= bus.mem_wr_data[CT_IRQ_EN];
            r_irq <= r_irq_en & w_empty & ~w_wr_data
                     & ~(w_wr_ctrl & ~bus.mem_wr_data[CT_IRQ_EN]);
        end
    end

    assign w_irq_en = r_irq_en;
    assign w_irq    = r_irq;
    assign w_unused = &{1'b0, bus.mem_wr_data[7:4]};
`else
    assign w_irq_en = 1'b0;
    assign w_irq    = 1'b0;
    assign w_unused = &{1'b0, bus.mem_wr_data[7:4], bus.mem_wr_data[CT_IRQ_EN]};
`endif

    always_comb begin
        w_rd_data = '0;
        if (bus.mem_rd && w_hit) begin
            case (w_sel)
                REG_STATUS: w_rd_data = pack_status(w_empty, w_full, r_ovf, w_irq);
                REG_COUNT:  w_rd_data = 8'(w_count);
                REG_CTRL:   w_rd_data = pack_ctrl(r_out_en, w_irq_en);
                default:    w_rd_data = '0;
            endcase
        end
    end

    assign bus.mem_rd_data = w_rd_data;
    assign bus.m_data      = w_dout;
    assign bus.m_valid     = ~w_empty & r_out_en;
    assign bus.irq         = w_irq;

endmodule

// File: tb/tb_tx_fifo_periph.sv
// Directed and random bench for tx_fifo_periph against a queue-based model of the register map.
// Interrupt expectations follow FIFO_IRQ_EN when the bench is built with the same define.
module tb_tx_fifo_periph;
    localparam int         DEPTH   = 16;
    localparam logic [5:0] BASE_HI = 6'h30;
    localparam logic [7:0] A_DATA  = 8'hC0;
    localparam logic [7:0] A_STAT  = 8'hC1;
    localparam logic [7:0] A_CNT   = 8'hC2;
    localparam logic [7:0] A_CTRL  = 8'hC3;
`ifdef FIFO_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tx_fifo_periph_if bus();

    tx_fifo_periph #(
        .BASE_ADDR  (8'hC0),
        .DEPTH_LOG2 (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    logic [7:0] exp_q[$];
    bit         m_ovf;
    bit         m_out_en;
    bit         m_irq_en;
    bit         m_irq;
    int         n_cmp  = 0;
    int         n_fail = 0;
    logic       rdy;

    function automatic bit exp_valid();
        return (exp_q.size() != 0) && m_out_en;
    endfunction

    function automatic logic [7:0] exp_read(input logic [7:0] a, input logic rd);
        logic [5:0] hi;
        logic [1:0] lo;
        hi = a[7:2];
        lo = a[1:0];
        if (!rd || hi != BASE_HI) return 8'h00;
        case (lo)
            2'd1:    return {4'b0, m_irq, m_ovf, exp_q.size() == DEPTH, exp_q.size() == 0};
            2'd2:    return 8'(exp_q.size());
            2'd3:    return {5'b0, m_irq_en, 1'b0, m_out_en};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ovf    = 0;
        m_out_en = 0;
        m_irq_en = 0;
        m_irq    = 0;
    endtask

    task automatic model_step(input logic [7:0] a, input logic wr, input logic [7:0] wd, input logic r);
        bit hit, push, ctrl, pop, irq_nxt, ovf_set;
        if (rst) begin
            model_reset();
            return;
        end
        hit     = (a[7:2] == BASE_HI);
        push    = wr && hit && (a[1:0] == 2'd0);
        ctrl    = wr && hit && (a[1:0] == 2'd3);
        pop     = exp_valid() && r;
        irq_nxt = IRQ_ON && m_irq_en && (exp_q.size() == 0) && !push && !(ctrl && !wd[2]);
        ovf_set = 0;
        if (ctrl && wd[1]) begin
            exp_q.delete();
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (push) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(wd);
                else ovf_set = 1;
            end
        end
        if (ovf_set)             m_ovf = 1;
        else if (ctrl && wd[3])  m_ovf = 0;
        if (ctrl) begin
            m_out_en = wd[0];
            m_irq_en = IRQ_ON && wd[2];
        end
        m_irq = irq_nxt;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%02h exp=%02h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks (entered and left at negedge) ----------------
    task automatic cyc(input logic [7:0] a, input logic wr, input logic rd, input logic [7:0] wd, input logic r);
        bus.mem_addr    = a;
        bus.mem_wr      = wr;
        bus.mem_rd      = rd;
        bus.mem_wr_data = wd;
        bus.m_ready     = r;
        #1;
        chk("m_valid", {7'b0, bus.m_valid}, {7'b0, exp_valid()});
        if (exp_valid()) chk("m_data", bus.m_data, exp_q[0]);
        chk("irq", {7'b0, bus.irq}, {7'b0, m_irq});
        chk("rd_data", bus.mem_rd_data, exp_read(a, rd));
        @(posedge clk);
        model_step(a, wr, wd, r);
        @(negedge clk);
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [7:0] d);
        cyc(a, 1'b1, 1'b0, d, rdy);
    endtask

    task automatic idle();
        cyc(8'h00, 1'b0, 1'b0, 8'h00, rdy);
    endtask

    task automatic rd_const(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bus.mem_addr = a;
        bus.mem_wr   = 1'b0;
        bus.mem_rd   = 1'b1;
        #1;
        chk(tag, bus.mem_rd_data, exp);
        cyc(a, 1'b0, 1'b1, 8'h00, rdy);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst             = 1'b1;
        rdy             = 1'b0;
        bus.mem_addr    = 8'h00;
        bus.mem_wr      = 1'b0;
        bus.mem_rd      = 1'b0;
        bus.mem_wr_data = 8'h00;
        bus.m_ready     = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // reset state
        chk("rst_m_valid", {7'b0, bus.m_valid}, 8'h00);
        chk("rst_irq", {7'b0, bus.irq}, 8'h00);
        rd_const("rst_status", A_STAT, 8'h01);
        rd_const("rst_count", A_CNT, 8'h00);

        // two bytes stream out in order
        rdy = 1'b1;
        wr_reg(A_DATA, 8'hA5);
        wr_reg(A_DATA, 8'h3C);
        wr_reg(A_CTRL, 8'h01);
        chk("t2_first", bus.m_data, 8'hA5);
        idle();
        chk("t2_second", bus.m_data, 8'h3C);
        idle();
        rd_const("t2_count", A_CNT, 8'h00);

        // overfill with output disabled
        rdy = 1'b0;
        wr_reg(A_CTRL, 8'h00);
        for (int i = 0; i < 17; i++) wr_reg(A_DATA, 8'h40 + 8'(i));
        rd_const("t3_status", A_STAT, 8'h06);
        rd_const("t3_count", A_CNT, 8'h10);

        // simultaneous push and pop on a full FIFO
        wr_reg(A_CTRL, 8'h08);
        rd_const("t4_ovf_clr", A_STAT, 8'h02);
        wr_reg(A_CTRL, 8'h01);
        cyc(A_DATA, 1'b1, 1'b0, 8'hEE, 1'b1);
        rd_const("t4_count", A_CNT, 8'h10);
        rd_const("t4_status", A_STAT, 8'h02);
        rdy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) chk("t4_last", bus.m_data, 8'hEE);
            idle();
        end
        rd_const("t4_drained", A_CNT, 8'h00);

        // flush discards queued bytes
        rdy = 1'b0;
        wr_reg(A_CTRL, 8'h00);
        for (int i = 0; i < 3; i++) wr_reg(A_DATA, 8'h70 + 8'(i));
        wr_reg(A_CTRL, 8'h02);
        chk("t5_m_valid", {7'b0, bus.m_valid}, 8'h00);
        rd_const("t5_status", A_STAT, 8'h01);
        rd_const("t5_count", A_CNT, 8'h00);

        // interrupt on empty, cleared by a push
        rdy = 1'b1;
        wr_reg(A_CTRL, 8'h05);
        idle();
        rd_const("t6_other0", 8'h80, 8'h00);
        wr_reg(A_DATA, 8'h11);
        rd_const("t6_other1", 8'h80, 8'h00);
        idle();
        idle();
        rd_const("t6_other2", 8'h80, 8'h00);
        wr_reg(A_CTRL, 8'h01);
        idle();

        // randomized traffic, including occasional mid-stream reset
        for (int n = 0; n < 600; n++) begin
            logic [7:0] a, d;
            int sel;
            sel = $urandom_range(0, 9);
            case (sel)
                0, 1, 2, 3, 4: a = A_DATA;
                5:             a = A_STAT;
                6:             a = A_CNT;
                7:             a = A_CTRL;
                8:             a = 8'h80;
                default:       a = 8'($urandom);
            endcase
            d = 8'($urandom);
            if (a == A_CTRL && $urandom_range(0, 3) != 0) d[1] = 1'b0;
            rst = ($urandom_range(0, 149) == 0);
            cyc(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d,
                1'($urandom_range(0, 2) == 0));
            rst = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
